counter_load_sequencer: RTL and testbench

- Upstream control stage for the 4-bit loadable up-counter (`clk`, `rst`, `load`, `data_in`, `count`).
- Accepts preset values over a valid/ready request port and buffers them in a small queue.
- Issues each preset to the counter as a single-cycle `load` pulse, then watches `count` until it reaches a terminal value.
- Signals segment completion before issuing the next preset, so the counter runs back-to-back segments without software pacing.

---
 rtl/counter_seq_pkg.sv | 14 +
 rtl/load_req_fifo.sv | 65 ++++++
 rtl/counter_load_sequencer.sv | 90 +++++++++
 tb/tb_counter_load_sequencer.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/counter_seq_pkg.sv
// Shared types and defaults for the counter load sequencer and its request FIFO.
package counter_seq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} seq_state_t;

    localparam int         WIDTH_DEF = 4;
    localparam logic [3:0] TERM_DEF  = 4'hF;

    // Occupancy counters need one more bit than the pointers, so that "full" can be told apart from "empty".
    function automatic int occ_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/load_req_fifo.sv
// Synchronous preset request FIFO that shows its head entry directly on rd_data.
// flush empties it and has priority over push and pop.
module load_req_fifo
    import counter_seq_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  logic [WIDTH-1:0]             wr_data,
    output logic [WIDTH-1:0]             rd_data,
    output logic                         full,
    output logic                         empty,
    output logic [occ_width(DEPTH)-1:0]  level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = occ_width(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LW'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign rd_data = mem[rd_ptr];

    // NOTE: storage has no reset; level gates every read, so stale entries are never observed.
    always_ff @(posedge clk) begin
        if (do_push && !flush)
            mem[wr_ptr] <= wr_data;
    end

    // NOTE: state registers use <= so every flop samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)
                rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/counter_load_sequencer.sv
// Feeds queued presets to the 4-bit loadable counter one segment at a time.
// A segment ends when the counter reaches TERM_VALUE.
module counter_load_sequencer
    import counter_seq_pkg::*;
#(
    parameter int             WIDTH      = WIDTH_DEF,
    parameter int             DEPTH      = 4,
    parameter logic [WIDTH-1:0] TERM_VALUE = TERM_DEF,
    parameter int             SEGW       = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         req_valid,
    input  logic [WIDTH-1:0]             req_data,
    output logic                         req_ready,
    input  logic                         abort,
    input  logic [WIDTH-1:0]             count,
    output logic                         load,
    output logic [WIDTH-1:0]             data_in,
    output logic                         busy,
    output logic                         seg_done,
    output logic [SEGW-1:0]              seg_count,
    output logic [occ_width(DEPTH)-1:0]  level
);

    seq_state_t       state;
    seq_state_t       state_next;
    logic [WIDTH-1:0] head;
    logic             full;
    logic             empty;
    logic             push;
    logic             pop;

    assign req_ready = !full;
    assign push      = req_valid && !full && !abort;
    assign busy      = (state != IDLE);

    load_req_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .pop     (pop),
        .flush   (abort),
        .wr_data (req_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // NOTE: every always_comb output gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_next = state;
        pop        = 1'b0;
        if (abort) begin
            state_next = IDLE;
        end else begin
            case (state)
                IDLE: if (!empty) begin
                    pop        = 1'b1;
                    state_next = LOAD;
                end
                LOAD:    state_next = RUN;
                RUN:     if (count == TERM_VALUE) state_next = DONE;
                DONE:    state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    // load and seg_done are registered decodes of the next state, so each is high for exactly its state's cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            load      <= 1'b0;
            data_in   <= '0;
            seg_done  <= 1'b0;
            seg_count <= '0;
        end else begin
            state    <= state_next;
            load     <= (state_next == LOAD);
            seg_done <= (state_next == DONE);
            if (pop)
                data_in <= head;
            if (state == DONE && !abort)
                seg_count <= seg_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_counter_load_sequencer.sv
// Self-checking bench: a behavioural 4-bit counter closes the loop, and a scoreboard tracks issued presets.
module tb_counter_load_sequencer;

    logic       clk = 1'b0;
    logic       rst;
    logic       req_valid;
    logic [3:0] req_data;
    logic       req_ready;
    logic       abort;
    logic [3:0] count;
    logic       load;
    logic [3:0] data_in;
    logic       busy;
    logic       seg_done;
    logic [7:0] seg_count;
    logic [2:0] level;

    int         n_cmp = 0;
    int         n_err = 0;
    int         seg_pulses = 0;
    logic [3:0] exp_q[$];
    int         seg_model = 0;
    int         p0;

    counter_load_sequencer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .abort     (abort),
        .count     (count),
        .load      (load),
        .data_in   (data_in),
        .busy      (busy),
        .seg_done  (seg_done),
        .seg_count (seg_count),
        .level     (level)
    );

    always #5 clk = ~clk;

    // The loadable up-counter that this sequencer drives.
    always @(posedge clk or posedge rst) begin
        if (rst)       count <= 4'd0;
        else if (load) count <= data_in;
        else           count <= count + 4'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every load strobe must carry the oldest outstanding preset.
    always @(negedge clk) begin
        if (!rst && load) begin
            if (exp_q.size() == 0) check("unexpected_load", load, 1'b0);
            else                   check("load_order", data_in, exp_q.pop_front());
        end
        if (!rst && seg_done) seg_pulses++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_req(input logic [3:0] v);
        int t = 0;
        req_valid = 1'b1;
        req_data  = v;
        while (!req_ready && t < 200) begin
            tick();
            t++;
        end
        if (!req_ready) check("push_timeout", req_ready, 1'b1);
        exp_q.push_back(v);
        tick();
        req_valid = 1'b0;
    endtask

    task automatic wait_pulses(input int target);
        int t = 0;
        while (seg_pulses < target && t < 2000) begin
            tick();
            t++;
        end
        tick();
        check("seg_wait", seg_pulses, target);
    endtask

    initial begin
        int t;
        rst = 1'b1; req_valid = 1'b0; req_data = 4'd0; abort = 1'b0;
        #12;
        check("rst_load", load, 0);
        check("rst_busy", busy, 0);
        check("rst_seg_done", seg_done, 0);
        check("rst_seg_count", seg_count, 0);
        check("rst_level", level, 0);
        check("rst_req_ready", req_ready, 1);
        @(posedge clk); #1 rst = 1'b0;

        // Reset mid-RUN with count at 14 must clear outputs without waiting for an edge.
        push_req(4'd12);
        repeat (4) tick();
        check("midrun_count", count, 14);
        check("midrun_busy", busy, 1);
        rst = 1'b1;
        #1;
        check("async_load", load, 0);
        check("async_busy", busy, 0);
        check("async_seg_done", seg_done, 0);
        check("async_seg_count", seg_count, 0);
        check("async_level", level, 0);
        tick();
        rst = 1'b0;

        // Single preset 13: exact cycle-by-cycle timing.
        push_req(4'd13);
        check("p13_e0_level", level, 1);
        check("p13_e0_load", load, 0);
        tick();
        check("p13_e1_load", load, 1);
        check("p13_e1_data", data_in, 13);
        check("p13_e1_busy", busy, 1);
        check("p13_e1_level", level, 0);
        tick();
        check("p13_e2_load", load, 0);
        check("p13_e2_count", count, 13);
        tick();
        check("p13_e3_count", count, 14);
        tick();
        check("p13_e4_count", count, 15);
        check("p13_e4_done", seg_done, 0);
        tick();
        check("p13_e5_done", seg_done, 1);
        tick();
        seg_model += 1;
        check("p13_e6_done", seg_done, 0);
        check("p13_e6_seg_count", seg_count, seg_model);
        check("p13_e6_busy", busy, 0);
        check("p13_data_hold", data_in, 13);

        // Preset equal to TERM_VALUE ends on the first RUN cycle.
        push_req(4'd15);
        tick();
        check("p15_e1_load", load, 1);
        tick();
        check("p15_e2_busy", busy, 1);
        tick();
        check("p15_e3_done", seg_done, 1);
        tick();
        seg_model += 1;
        check("p15_e4_done", seg_done, 0);
        check("p15_seg_count", seg_count, seg_model);

        // Back-pressure: fill the queue while a long segment runs.
        p0 = seg_pulses;
        push_req(4'd0);
        tick(); tick();
        for (int i = 1; i <= 4; i++) push_req(4'(i));
        check("bp_ready", req_ready, 0);
        check("bp_level", level, 4);
        check("bp_busy", busy, 1);
        push_req(4'd5);
        wait_pulses(p0 + 6);
        seg_model += 6;
        check("bp_seg_count", seg_count, seg_model);
        check("bp_level_end", level, 0);
        check("bp_busy_end", busy, 0);

        // Simultaneous push and pop at level 2.
        p0 = seg_pulses;
        push_req(4'd10);
        tick(); tick();
        push_req(4'd7);
        push_req(4'd8);
        check("pp_level_pre", level, 2);
        t = 0;
        while (!seg_done && t < 100) begin
            tick();
            t++;
        end
        check("pp_seg_done_seen", seg_done, 1);
        tick();
        check("pp_idle", busy, 0);
        check("pp_level_idle", level, 2);
        req_valid = 1'b1;
        req_data  = 4'd9;
        exp_q.push_back(4'd9);
        tick();
        req_valid = 1'b0;
        check("pp_level_same", level, 2);
        check("pp_load", load, 1);
        check("pp_oldest", data_in, 7);
        wait_pulses(p0 + 4);
        seg_model += 4;
        check("pp_seg_count", seg_count, seg_model);

        // abort during RUN with level 3 and a request in the same cycle.
        push_req(4'd0);
        tick(); tick();
        push_req(4'd1);
        push_req(4'd2);
        push_req(4'd3);
        check("ab_level_pre", level, 3);
        check("ab_busy_pre", busy, 1);
        req_valid = 1'b1;
        req_data  = 4'd9;
        abort     = 1'b1;
        tick();
        abort     = 1'b0;
        req_valid = 1'b0;
        exp_q.delete();
        check("ab_level", level, 0);
        check("ab_busy", busy, 0);
        check("ab_load", load, 0);
        check("ab_seg_done", seg_done, 0);
        check("ab_seg_count", seg_count, seg_model);
        check("ab_data_kept", data_in, 0);
        repeat (30) tick();
        check("ab_level_after", level, 0);
        check("ab_busy_after", busy, 0);
        check("ab_seg_count_after", seg_count, seg_model);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
